alu_arbiter: RTL and testbench

- Shares one instance of the team's 32-bit `ALU` between `N_REQ` requesters using per-requester valid/ready handshakes.
- Per operation: arbitrates, latches operands into a local register, runs the ALU for one cycle, then returns the registered result and NZCV flags to the granted requester.
- Sits between the ALU and its users (decode/execute front-ends, address-generation unit).
- Keeps a copy of the most recent flags for status readout.

---
 rtl/alu_arb_pkg.sv | 13 +
 rtl/ALU.sv | 41 ++++
 rtl/alu_arb_pick.sv | 25 ++
 rtl/alu_arbiter.sv | 86 ++++++++
 tb/tb_alu_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared state encoding, field widths and flag bit positions for alu_arbiter.
package alu_arb_pkg;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam int OP_W = 2;
  localparam int CMD_W = 4;
  localparam int FLAG_W = 4;
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;
endpackage

// File: rtl/ALU.sv
// ALU: combinational ALU; OP shifts B by one (0 none, 1 LSL, 2 LSR, 3 ASR), cmd uses ARM opcode numbering
// without carry-in (ADC/SBC/RSC act as ADD/SUB/RSB, TST/TEQ/CMP/CMN return their AND/EOR/SUB/ADD result).
module ALU
  import alu_arb_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0]      Aport,
  input  logic [W-1:0]      Bport,
  input  logic [OP_W-1:0]   OP,
  input  logic [CMD_W-1:0]  cmd,
  output logic [W-1:0]      ALU_out,
  output logic [FLAG_W-1:0] flags
);
  logic [W-1:0] b_sh, x, y, yy, lg;
  logic [W:0] sum;
  logic sub, rev, arith;
  always_comb begin
    b_sh = OP == 2'd1 ? {Bport[W-2:0], 1'b0} :
           OP == 2'd2 ? {1'b0, Bport[W-1:1]} :
           OP == 2'd3 ? {Bport[W-1], Bport[W-1:1]} : Bport;
    sub = cmd inside {4'd2, 4'd3, 4'd6, 4'd7, 4'd10};
    arith = sub | (cmd inside {4'd4, 4'd5, 4'd11});
    rev = cmd inside {4'd3, 4'd7};
    x = rev ? b_sh : Aport;
    y = rev ? Aport : b_sh;
    yy = sub ? ~y : y;
    sum = {1'b0, x} + {1'b0, yy} + (W + 1)'(sub);
    lg = cmd[3:2] == 2'b11 ? (cmd[1:0] == 2'd0 ? Aport | b_sh :
                              cmd[1:0] == 2'd1 ? b_sh :
                              cmd[1:0] == 2'd2 ? Aport & ~b_sh : ~b_sh) :
         cmd[0] ? Aport ^ b_sh : Aport & b_sh;
    ALU_out = arith ? sum[W-1:0] : lg;
    flags = '0;
    flags[FLAG_N] = ALU_out[W-1];
    flags[FLAG_Z] = ALU_out == '0;
    // C is carry-out for add and no-borrow for subtract; logic ops clear C and V
    flags[FLAG_C] = arith & sum[W];
    flags[FLAG_V] = arith & (x[W-1] == yy[W-1]) & (sum[W-1] != x[W-1]);
  end
endmodule

// File: rtl/alu_arb_pick.sv
// alu_arb_pick: one-hot picker, grants the first set request searching upward from ptr modulo N.
module alu_arb_pick #(
  parameter int N = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);
  always_comb begin
    int j;
    j = 0;
    gnt = '0;
    idx = '0;
    // scan from farthest to nearest so the nearest set bit is the final write
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N;
      if (req[j]) begin
        gnt = N'(1) << j;
        idx = IW'(j);
      end
    end
  end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU among N_REQ requesters with valid/ready handshakes (IDLE->EXEC->RESP).
// Define ALU_ARB_RR_EN for round-robin arbitration; otherwise the lowest requester index wins.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int DW = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*DW-1:0]     req_a,
  input  logic [N_REQ*DW-1:0]     req_b,
  input  logic [N_REQ*OP_W-1:0]   req_op,
  input  logic [N_REQ*CMD_W-1:0]  req_cmd,
  output logic [N_REQ-1:0]        rsp_valid,
  input  logic [N_REQ-1:0]        rsp_ready,
  output logic [DW-1:0]           rsp_result,
  output logic [FLAG_W-1:0]       rsp_flags,
  output logic [FLAG_W-1:0]       last_flags,
  output logic                    busy
);
  localparam int IW = $clog2(N_REQ);
  logic [1:0] state;
  logic [IW-1:0] gnt_idx, ptr, pick_idx;
  logic [N_REQ-1:0] pick_gnt;
  logic [DW-1:0] a_q, b_q, alu_out;
  logic [OP_W-1:0] op_q;
  logic [CMD_W-1:0] cmd_q;
  logic [FLAG_W-1:0] alu_flags;
  alu_arb_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .req(req_valid),
    .ptr(ptr),
    .gnt(pick_gnt),
    .idx(pick_idx)
  );
  ALU #(.W(DW)) u_alu (
    .Aport(a_q),
    .Bport(b_q),
    .OP(op_q),
    .cmd(cmd_q),
    .ALU_out(alu_out),
    .flags(alu_flags)
  );
  assign busy = state != S_IDLE;
  assign req_ready = (state == S_IDLE) ? pick_gnt : '0;
  assign rsp_valid = (state == S_RESP) ? N_REQ'(1) << gnt_idx : '0;
`ifdef ALU_ARB_RR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr <= '0;
    else if (state == S_IDLE && |req_valid) ptr <= (pick_idx == IW'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
  end
`else
  assign ptr = '0;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      gnt_idx <= '0;
      a_q <= '0;
      b_q <= '0;
      op_q <= '0;
      cmd_q <= '0;
      rsp_result <= '0;
      rsp_flags <= '0;
      last_flags <= '0;
    end else if (state == S_IDLE) begin
      if (|req_valid) begin
        state <= S_EXEC;
        gnt_idx <= pick_idx;
        a_q <= req_a[pick_idx*DW +: DW];
        b_q <= req_b[pick_idx*DW +: DW];
        op_q <= req_op[pick_idx*OP_W +: OP_W];
        cmd_q <= req_cmd[pick_idx*CMD_W +: CMD_W];
      end
    end else if (state == S_EXEC) begin
      state <= S_RESP;
      rsp_result <= alu_out;
      rsp_flags <= alu_flags;
      last_flags <= alu_flags;
    end else if (rsp_ready[gnt_idx]) begin
      state <= S_IDLE;
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and random stimulus for alu_arbiter checked against a transaction-level model.
module tb_alu_arbiter;
  localparam int N = 2;
  localparam int DW = 32;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] req_valid = '0, rsp_ready = '0, req_ready, rsp_valid, acc;
  logic [DW-1:0] a_r [N];
  logic [DW-1:0] b_r [N];
  logic [1:0] op_r [N];
  logic [3:0] cmd_r [N];
  logic [N*DW-1:0] req_a, req_b;
  logic [N*2-1:0] req_op;
  logic [N*4-1:0] req_cmd;
  logic [DW-1:0] rsp_result;
  logic [3:0] rsp_flags, last_flags;
  logic busy;
  int checks = 0, errors = 0;
  int m_mode = 0, m_owner = 0, m_ptr = 0;
  logic [31:0] m_res = '0, e_res = '0;
  logic [3:0] m_flags = '0, m_last = '0, e_flags = '0;
  int obs [$];
  assign req_a = {a_r[1], a_r[0]};
  assign req_b = {b_r[1], b_r[0]};
  assign req_op = {op_r[1], op_r[0]};
  assign req_cmd = {cmd_r[1], cmd_r[0]};
  always #5 clk = ~clk;
  alu_arbiter #(.N_REQ(N), .DW(DW)) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a(req_a),
    .req_b(req_b),
    .req_op(req_op),
    .req_cmd(req_cmd),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_result(rsp_result),
    .rsp_flags(rsp_flags),
    .last_flags(last_flags),
    .busy(busy)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic bit ovf(input longint x);
    return longint'(int'(x)) != x;
  endfunction
  // reference ALU: {N,Z,C,V,result} from plain unsigned/signed arithmetic
  function automatic logic [35:0] alu_ref(input logic [31:0] a, b, input logic [1:0] op, input logic [3:0] cmd);
    logic signed [31:0] bs;
    logic [31:0] s, r;
    logic c, v;
    longint wide;
    bs = b;
    c = 1'b0;
    v = 1'b0;
    case (op)
      2'd1: s = b << 1;
      2'd2: s = b >> 1;
      2'd3: s = bs >>> 1;
      default: s = b;
    endcase
    case (cmd)
      4'd4, 4'd5, 4'd11: begin
        wide = longint'(a) + longint'(s);
        r = wide[31:0];
        c = wide[32];
        v = ovf(longint'($signed(a)) + longint'($signed(s)));
      end
      4'd2, 4'd6, 4'd10: begin
        r = a - s;
        c = a >= s;
        v = ovf(longint'($signed(a)) - longint'($signed(s)));
      end
      4'd3, 4'd7: begin
        r = s - a;
        c = s >= a;
        v = ovf(longint'($signed(s)) - longint'($signed(a)));
      end
      4'd0, 4'd8: r = a & s;
      4'd1, 4'd9: r = a ^ s;
      4'd12: r = a | s;
      4'd13: r = s;
      4'd14: r = a & ~s;
      default: r = ~s;
    endcase
    return {r[31], r == 32'd0, c, v, r};
  endfunction
  function automatic int model_pick(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
`ifdef ALU_ARB_RR_EN
      int j = (m_ptr + k) % N;
`else
      int j = k;
`endif
      if (v[j]) return j;
    end
    return -1;
  endfunction
  task automatic set_req(input int i, input logic [31:0] a, b, input logic [1:0] op, input logic [3:0] cmd);
    a_r[i] = a;
    b_r[i] = b;
    op_r[i] = op;
    cmd_r[i] = cmd;
    req_valid[i] = 1'b1;
  endtask
  task automatic rand_req(input int i);
    set_req(i, $urandom, $urandom, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
  endtask
  task automatic reset_model();
    m_mode = 0;
    m_ptr = 0;
    m_res = '0;
    m_flags = '0;
    m_last = '0;
  endtask
  // called at posedge+1 with inputs driven: check outputs, clock once, advance the model
  task automatic cycle();
    int p;
    #1;
    p = model_pick(req_valid);
    chk("busy", busy, m_mode != 0);
    chk("req_ready", req_ready, (m_mode == 0 && p >= 0) ? (1 << p) : 0);
    chk("rsp_valid", rsp_valid, m_mode == 2 ? (1 << m_owner) : 0);
    chk("rsp_result", rsp_result, m_res);
    chk("rsp_flags", rsp_flags, m_flags);
    chk("last_flags", last_flags, m_last);
    for (int i = 0; i < N; i++) if (req_valid[i] && req_ready[i]) obs.push_back(i);
    acc = '0;
    @(posedge clk);
    if (m_mode == 0) begin
      if (p >= 0) begin
        m_owner = p;
        {e_flags, e_res} = alu_ref(a_r[p], b_r[p], op_r[p], cmd_r[p]);
        m_ptr = (p + 1) % N;
        acc[p] = 1'b1;
        m_mode = 1;
      end
    end else if (m_mode == 1) begin
      m_res = e_res;
      m_flags = e_flags;
      m_last = e_flags;
      m_mode = 2;
    end else if (rsp_ready[m_owner]) begin
      m_mode = 0;
    end
    #1;
  endtask
  task automatic drain();
    for (int k = 0; k < 30 && busy; k++) cycle();
    chk("drain_timeout", busy, 1'b0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int base, cnt;
    int exp_order [4];
    for (int i = 0; i < N; i++) begin
      a_r[i] = '0;
      b_r[i] = '0;
      op_r[i] = '0;
      cmd_r[i] = '0;
    end
    @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_rsp_valid", rsp_valid, 2'b00);
    chk("rst_result", rsp_result, 32'd0);
    chk("rst_flags", rsp_flags, 4'd0);
    chk("rst_last_flags", last_flags, 4'd0);
    rst = 1'b0;
    // single ADD request from requester 0
    rsp_ready = 2'b11;
    set_req(0, 32'h00011111, 32'h1, 2'd0, 4'd4);
    #1;
    chk("single_ready", req_ready, 2'b01);
    cycle();
    req_valid &= ~acc;
    cycle();
    chk("single_valid", rsp_valid, 2'b01);
    chk("single_result", rsp_result, 32'h00011112);
    chk("single_flags", rsp_flags, 4'b0000);
    cycle();
    // SUB sets carry; last_flags follows on the same edge
    set_req(1, 32'd15, 32'd14, 2'd0, 4'd2);
    cycle();
    req_valid &= ~acc;
    cycle();
    chk("flags_result", rsp_result, 32'd1);
    chk("flags_rsp", rsp_flags, 4'b0010);
    chk("flags_last", last_flags, 4'b0010);
    drain();
    // contention: both requesters stay valid, re-requesting as soon as accepted
    obs.delete();
    rand_req(0);
    rand_req(1);
    for (int k = 0; k < 40 && obs.size() < 4; k++) begin
      cycle();
      for (int i = 0; i < N; i++) if (acc[i]) rand_req(i);
    end
    req_valid = '0;
    drain();
`ifdef ALU_ARB_RR_EN
    exp_order = '{0, 1, 0, 1};
`else
    exp_order = '{0, 0, 0, 0};
`endif
    chk("contention_count", obs.size() >= 4, 1'b1);
    for (int k = 0; k < 4; k++) chk($sformatf("contention_grant%0d", k), obs.size() > k ? obs[k] : -1, exp_order[k]);
    // back-pressure: response held five cycles while requester 1 waits
    rsp_ready = 2'b00;
    set_req(0, 32'd7, 32'd9, 2'd1, 4'd4);
    cycle();
    req_valid &= ~acc;
    rand_req(1);
    cycle();
    repeat (5) begin
      chk("bp_valid", rsp_valid, 2'b01);
      chk("bp_result", rsp_result, 32'd25);
      chk("bp_no_ready", req_ready, 2'b00);
      cycle();
    end
    rsp_ready = 2'b01;
    cycle();
    chk("bp_next_grant", req_ready, 2'b10);
    cycle();
    req_valid &= ~acc;
    rsp_ready = 2'b11;
    drain();
    // withdrawn request: requester 1 gives up while requester 0 is served
    base = obs.size();
    rsp_ready = 2'b00;
    rand_req(0);
    cycle();
    req_valid &= ~acc;
    rand_req(1);
    cycle();
    cycle();
    req_valid[1] = 1'b0;
    cycle();
    rsp_ready = 2'b11;
    cycle();
    repeat (3) cycle();
    cnt = 0;
    for (int k = base; k < obs.size(); k++) if (obs[k] == 1) cnt++;
    chk("withdrawn_grants", cnt, 0);
    chk("withdrawn_rsp", rsp_valid, 2'b00);
    // asynchronous reset while in EXEC
    set_req(1, 32'd15, 32'd14, 2'd0, 4'd2);
    cycle();
    req_valid &= ~acc;
    chk("pre_rst_busy", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_rsp_valid", rsp_valid, 2'b00);
    chk("arst_result", rsp_result, 32'd0);
    chk("arst_flags", rsp_flags, 4'd0);
    chk("arst_last_flags", last_flags, 4'd0);
    reset_model();
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) begin
      cycle();
      chk("arst_no_rsp", rsp_valid, 2'b00);
    end
    set_req(0, 32'd100, 32'd23, 2'd0, 4'd2);
    cycle();
    req_valid &= ~acc;
    cycle();
    chk("fresh_result", rsp_result, 32'd77);
    chk("fresh_flags", rsp_flags, 4'b0010);
    drain();
    // random traffic against the model
    repeat (400) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) == 0) rand_req(i);
        else if (req_valid[i] && $urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
      end
      rsp_ready = N'($urandom);
      cycle();
      req_valid &= ~acc;
    end
    req_valid = '0;
    rsp_ready = 2'b11;
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
